// File: rtl/srio_pkg.sv
// Shared SRIO constants, arbiter state encoding and a small index-width helper.
package srio_pkg;

  localparam logic [3:0] FTYPE_DOORB = 4'hA;
  localparam logic [3:0] FTYPE_NWR   = 4'h5;
  localparam logic [3:0] TTYPE_NWR   = 4'h4;

  localparam int TDATA_W = 64;
  localparam int TKEEP_W = 8;
  localparam int TUSER_W = 32;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_PKT  = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ireq_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder; first set request at or above i_ptr, wrapping.
module rr_pick
  import srio_pkg::*;
#(
  parameter int N = 2,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_grant,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  logic [N-1:0] w_rot;
  logic [W:0]   w_sum;

  // rotate so that bit 0 is the requester the pointer names
  assign w_rot = N'({i_req, i_req} >> i_ptr);

  always_comb begin
    o_any = |i_req;
    w_sum = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_sum = {1'b0, i_ptr} + (W + 1)'(k);
    end
    if (w_sum >= (W + 1)'(N)) w_sum = w_sum - (W + 1)'(N);
    o_idx   = w_sum[W-1:0];
    o_grant = o_any ? (N'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/ireq_arbiter.sv
// Packet-level round-robin arbiter sharing the SRIO ireq AXI-Stream channel between NUM_REQ requesters.
// Optional stall watchdog enabled by defining IREQ_ARB_WDOG_EN.
module ireq_arbiter
  import srio_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int PKT_CNT_W   = 16,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                       log_clk,
  input  logic                       log_rst,
  input  logic [NUM_REQ-1:0]         req_tvalid_in,
  output logic [NUM_REQ-1:0]         req_tready_o,
  input  logic [NUM_REQ-1:0]         req_tlast_in,
  input  logic [TDATA_W*NUM_REQ-1:0] req_tdata_in,
  input  logic [TKEEP_W*NUM_REQ-1:0] req_tkeep_in,
  input  logic [TUSER_W*NUM_REQ-1:0] req_tuser_in,
  output logic                       ireq_tvalid_o,
  input  logic                       ireq_tready_in,
  output logic                       ireq_tlast_o,
  output logic [TDATA_W-1:0]         ireq_tdata_o,
  output logic [TKEEP_W-1:0]         ireq_tkeep_o,
  output logic [TUSER_W-1:0]         ireq_tuser_o,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic                       busy_o,
  output logic [PKT_CNT_W-1:0]       pkt_cnt_o,
  output logic                       wdog_err_o
);

  localparam int IW = idx_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 2) begin : g_bad_param
    $error("ireq_arbiter: NUM_REQ must be 2..8 and WDOG_CYCLES at least 2");
  end

  arb_state_e           r_state, w_next;
  logic [NUM_REQ-1:0]   r_grant;
  logic [IW-1:0]        r_gidx, r_ptr, w_ptr_next;
  logic [PKT_CNT_W-1:0] r_pkt_cnt;
  logic [NUM_REQ-1:0]   w_pick_grant;
  logic [IW-1:0]        w_pick_idx;
  logic                 w_pick_any;
  logic                 w_acc, w_last_acc, w_wdog_fire;

  rr_pick #(.N(NUM_REQ), .W(IW)) u_pick (
    .i_req   (req_tvalid_in),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  assign w_acc      = ireq_tvalid_o & ireq_tready_in;
  assign w_last_acc = w_acc & ireq_tlast_o;
  assign w_ptr_next = (r_gidx == IW'(NUM_REQ - 1)) ? '0 : r_gidx + IW'(1);

  always_ff @(posedge log_clk) begin
    if (log_rst) r_state <= ARB_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE: if (w_pick_any) w_next = ARB_PKT;
      ARB_PKT:  if (w_last_acc || w_wdog_fire) w_next = ARB_IDLE;
      default:  w_next = ARB_IDLE;
    endcase
  end

  // grant is latched only in IDLE, so it cannot move while a beat is pending
  always_ff @(posedge log_clk) begin
    if (log_rst) begin
      r_grant   <= '0;
      r_gidx    <= '0;
      r_ptr     <= '0;
      r_pkt_cnt <= '0;
    end else begin
      if (r_state == ARB_IDLE && w_pick_any) begin
        r_grant <= w_pick_grant;
        r_gidx  <= w_pick_idx;
      end
      if (r_state == ARB_PKT && (w_last_acc || w_wdog_fire)) begin
        r_grant <= '0;
        r_ptr   <= w_ptr_next;
      end
      if (r_state == ARB_PKT && w_last_acc) r_pkt_cnt <= r_pkt_cnt + PKT_CNT_W'(1);
    end
  end

  always_comb begin
    req_tready_o  = '0;
    ireq_tvalid_o = 1'b0;
    ireq_tlast_o  = 1'b0;
    ireq_tdata_o  = '0;
    ireq_tkeep_o  = '0;
    ireq_tuser_o  = '0;
    if (r_state == ARB_PKT) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_grant[i]) begin
          req_tready_o[i] = ireq_tready_in;
          ireq_tvalid_o   = req_tvalid_in[i];
          ireq_tlast_o    = req_tlast_in[i];
          ireq_tdata_o    = req_tdata_in[i*TDATA_W +: TDATA_W];
          ireq_tkeep_o    = req_tkeep_in[i*TKEEP_W +: TKEEP_W];
          ireq_tuser_o    = req_tuser_in[i*TUSER_W +: TUSER_W];
        end
      end
    end
  end

  assign grant_o   = r_grant;
  assign busy_o    = (r_state == ARB_PKT);
  assign pkt_cnt_o = r_pkt_cnt;

`ifdef IREQ_ARB_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);

  logic [WDW-1:0] r_stall;
  logic           r_wdog_err;

  // fires on the WDOG_CYCLES-th consecutive cycle without an accepted beat
  assign w_wdog_fire = (r_state == ARB_PKT) && !w_acc && (r_stall == WDW'(WDOG_CYCLES - 1));

  always_ff @(posedge log_clk) begin
    if (log_rst) begin
      r_stall    <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      r_wdog_err <= w_wdog_fire;
      if (r_state != ARB_PKT || w_acc || w_wdog_fire) r_stall <= '0;
      else                                            r_stall <= r_stall + WDW'(1);
    end
  end

  assign wdog_err_o = r_wdog_err;
`else
  assign w_wdog_fire = 1'b0;
  assign wdog_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_ireq_arbiter.sv
// Self-checking bench for ireq_arbiter: vector table plus directed multi-cycle sequences.
module tb_ireq_arbiter;
  import srio_pkg::*;

  localparam int N  = 2;
  localparam int WD = 16;

  logic            log_clk = 1'b0;
  logic            log_rst = 1'b1;
  logic [N-1:0]    req_tvalid_in = '0;
  logic [N-1:0]    req_tready_o;
  logic [N-1:0]    req_tlast_in = '0;
  logic [64*N-1:0] req_tdata_in = '0;
  logic [8*N-1:0]  req_tkeep_in = '0;
  logic [32*N-1:0] req_tuser_in = '0;
  logic            ireq_tvalid_o;
  logic            ireq_tready_in = 1'b0;
  logic            ireq_tlast_o;
  logic [63:0]     ireq_tdata_o;
  logic [7:0]      ireq_tkeep_o;
  logic [31:0]     ireq_tuser_o;
  logic [N-1:0]    grant_o;
  logic            busy_o;
  logic [15:0]     pkt_cnt_o;
  logic            wdog_err_o;

  ireq_arbiter #(.NUM_REQ(N), .PKT_CNT_W(16), .WDOG_CYCLES(WD)) dut (
    .log_clk(log_clk), .log_rst(log_rst),
    .req_tvalid_in(req_tvalid_in), .req_tready_o(req_tready_o), .req_tlast_in(req_tlast_in),
    .req_tdata_in(req_tdata_in), .req_tkeep_in(req_tkeep_in), .req_tuser_in(req_tuser_in),
    .ireq_tvalid_o(ireq_tvalid_o), .ireq_tready_in(ireq_tready_in), .ireq_tlast_o(ireq_tlast_o),
    .ireq_tdata_o(ireq_tdata_o), .ireq_tkeep_o(ireq_tkeep_o), .ireq_tuser_o(ireq_tuser_o),
    .grant_o(grant_o), .busy_o(busy_o), .pkt_cnt_o(pkt_cnt_o), .wdog_err_o(wdog_err_o)
  );

  always #5 log_clk = ~log_clk;

  int n_tests = 0;
  int n_fail  = 0;

  int           beat [N];
  int           plen [N];
  logic [N-1:0] en;
  logic [N-1:0] rdy_s, vld_s;

  typedef struct {
    logic [1:0]  tv, tl;
    logic        trdy;
    logic [1:0]  e_grant;
    logic        e_vld;
    logic [1:0]  e_rdy;
    logic        e_last;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt [13];

  localparam logic [63:0] D0 = 64'h00A0_2000_0101_0000;
  localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
  localparam logic [31:0] U0 = 32'h0001_0002;
  localparam logic [31:0] U1 = 32'h0003_0004;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name, input int budget);
    n_tests++;
    n_fail++;
    $display("FAIL %s: required DUT event not seen within %0d cycles", name, budget);
  endtask

  task automatic step();
    @(posedge log_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge log_clk);
    rdy_s = req_tready_o;
    vld_s = req_tvalid_in;
  endtask

  function automatic logic [63:0] mk_data(input int r, input int b);
    return {8'hD0, 8'(r), 16'h5A5A, 32'(b)};
  endfunction

  function automatic vec_t mkv(input logic [1:0] tv, input logic [1:0] tl, input logic trdy,
                               input logic [1:0] g, input logic v, input logic [1:0] r,
                               input logic l, input logic [15:0] c);
    vec_t x;
    x.tv = tv; x.tl = tl; x.trdy = trdy; x.e_grant = g;
    x.e_vld = v; x.e_rdy = r; x.e_last = l; x.e_cnt = c;
    return x;
  endfunction

  task automatic drive_srcs();
    for (int i = 0; i < N; i++) begin
      req_tdata_in[i*64 +: 64] = mk_data(i, beat[i]);
      req_tkeep_in[i*8 +: 8]   = 8'hFF;
      req_tuser_in[i*32 +: 32] = {16'(i + 1), 16'h0100};
      req_tlast_in[i]          = (beat[i] == plen[i] - 1);
      req_tvalid_in[i]         = en[i];
    end
  endtask

  task automatic advance();
    for (int i = 0; i < N; i++)
      if (rdy_s[i] && vld_s[i]) beat[i] = (beat[i] == plen[i] - 1) ? 0 : beat[i] + 1;
  endtask

  task automatic do_reset();
    log_rst = 1'b1;
    en = '0;
    for (int i = 0; i < N; i++) begin beat[i] = 0; plen[i] = 4; end
    drive_srcs();
    ireq_tready_in = 1'b0;
    step();
    step();
    log_rst = 1'b0;
  endtask

  // runs sources until requester r has had nacc beats accepted
  task automatic run_until(input int r, input int nacc, input string nm);
    int got;
    got = 0;
    for (int c = 0; c < 30 && got < nacc; c++) begin
      drive_srcs();
      sample();
      if (ireq_tvalid_o && ireq_tready_in && req_tready_o[r]) got++;
      step();
      advance();
    end
    if (got < nacc) tmo(nm, 30);
  endtask

  initial begin
    vt[0]  = mkv(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 16'd0);
    vt[1]  = mkv(2'b01, 2'b01, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 16'd0);
    vt[2]  = mkv(2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 2'b01, 1'b1, 16'd0);
    vt[3]  = mkv(2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 16'd1);
    vt[4]  = mkv(2'b11, 2'b11, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 16'd1);
    vt[5]  = mkv(2'b11, 2'b11, 1'b1, 2'b10, 1'b1, 2'b10, 1'b1, 16'd1);
    vt[6]  = mkv(2'b11, 2'b11, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 16'd2);
    vt[7]  = mkv(2'b11, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 16'd2);
    vt[8]  = mkv(2'b10, 2'b00, 1'b1, 2'b01, 1'b0, 2'b01, 1'b0, 16'd2);
    vt[9]  = mkv(2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 2'b01, 1'b1, 16'd2);
    vt[10] = mkv(2'b01, 2'b01, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 16'd3);
    vt[11] = mkv(2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 2'b01, 1'b1, 16'd3);
    vt[12] = mkv(2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 16'd4);

    // reset state and vector table
    do_reset();
    sample();
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_cnt", 64'(pkt_cnt_o), 64'd0);
    chk("rst_tvalid", 64'(ireq_tvalid_o), 64'd0);
    chk("rst_wdog", 64'(wdog_err_o), 64'd0);
    step();
    for (int v = 0; v < 13; v++) begin
      req_tvalid_in = vt[v].tv;
      req_tlast_in  = vt[v].tl;
      ireq_tready_in = vt[v].trdy;
      req_tdata_in  = {D1, D0};
      req_tkeep_in  = {8'hFF, 8'h0F};
      req_tuser_in  = {U1, U0};
      sample();
      chk($sformatf("v%0d_grant", v), 64'(grant_o), 64'(vt[v].e_grant));
      chk($sformatf("v%0d_busy", v), 64'(busy_o), 64'(vt[v].e_grant != 2'b00));
      chk($sformatf("v%0d_tvalid", v), 64'(ireq_tvalid_o), 64'(vt[v].e_vld));
      chk($sformatf("v%0d_tready", v), 64'(req_tready_o), 64'(vt[v].e_rdy));
      chk($sformatf("v%0d_tlast", v), 64'(ireq_tlast_o), 64'(vt[v].e_last));
      chk($sformatf("v%0d_cnt", v), 64'(pkt_cnt_o), 64'(vt[v].e_cnt));
      chk($sformatf("v%0d_wdog", v), 64'(wdog_err_o), 64'd0);
      if (vt[v].e_grant == 2'b01) begin
        chk($sformatf("v%0d_data", v), ireq_tdata_o, D0);
        chk($sformatf("v%0d_keep", v), 64'(ireq_tkeep_o), 64'h0F);
        chk($sformatf("v%0d_user", v), 64'(ireq_tuser_o), 64'(U0));
      end else if (vt[v].e_grant == 2'b10) begin
        chk($sformatf("v%0d_data", v), ireq_tdata_o, D1);
        chk($sformatf("v%0d_user", v), 64'(ireq_tuser_o), 64'(U1));
      end
      step();
    end

    // contention: two continuous 4-beat streams, 5-cycle period per packet
    do_reset();
    en = 2'b11;
    ireq_tready_in = 1'b1;
    for (int c = 0; c < 20; c++) begin
      int own;
      own = (c / 5) % 2;
      drive_srcs();
      sample();
      if (c % 5 == 0) begin
        chk($sformatf("cont_idle_c%0d", c), 64'(grant_o), 64'd0);
      end else begin
        chk($sformatf("cont_grant_c%0d", c), 64'(grant_o), 64'(2'b01 << own));
        chk($sformatf("cont_rdy_c%0d", c), 64'(req_tready_o), 64'(2'b01 << own));
        chk($sformatf("cont_data_c%0d", c), ireq_tdata_o, mk_data(own, (c % 5) - 1));
        chk($sformatf("cont_last_c%0d", c), 64'(ireq_tlast_o), 64'((c % 5) == 4));
      end
      step();
      advance();
    end
    sample();
    chk("cont_cnt", 64'(pkt_cnt_o), 64'd4);
    step();

    // backpressure on an 8-beat packet from requester 1
    do_reset();
    plen[1] = 8;
    en = 2'b10;
    begin
      int acc_n;
      acc_n = 0;
      for (int c = 0; c < 40 && acc_n < 8; c++) begin
        ireq_tready_in = (c % 2 == 0);
        drive_srcs();
        sample();
        if (req_tready_o[0] !== 1'b0) chk($sformatf("bp_rdy0_c%0d", c), 64'(req_tready_o[0]), 64'd0);
        if (ireq_tvalid_o && ireq_tready_in) begin
          chk($sformatf("bp_data_b%0d", acc_n), ireq_tdata_o, mk_data(1, acc_n));
          chk($sformatf("bp_last_b%0d", acc_n), 64'(ireq_tlast_o), 64'(acc_n == 7));
          acc_n++;
        end
        step();
        advance();
      end
      if (acc_n < 8) tmo("bp_beats", 40);
      en = 2'b00;
      drive_srcs();
      sample();
      chk("bp_cnt", 64'(pkt_cnt_o), 64'd1);
      chk("bp_idle", 64'(grant_o), 64'd0);
      step();
    end

    // requester 0 stalls 5 cycles before its last beat while requester 1 waits
    do_reset();
    plen[0] = 4;
    plen[1] = 1;
    en = 2'b11;
    ireq_tready_in = 1'b1;
    begin
      int  gap;
      bit  gap_done, owned, done0;
      gap = 0; gap_done = 0; owned = 0; done0 = 0;
      for (int c = 0; c < 40 && !done0; c++) begin
        if (beat[0] == 3 && !gap_done) begin gap = 5; gap_done = 1; end
        en[0] = (gap == 0);
        if (gap > 0) gap--;
        drive_srcs();
        sample();
        if (grant_o != 2'b00) owned = 1;
        if (owned) begin
          chk($sformatf("bub_grant_c%0d", c), 64'(grant_o), 64'd1);
          chk($sformatf("bub_rdy1_c%0d", c), 64'(req_tready_o[1]), 64'd0);
          if (!en[0]) chk($sformatf("bub_pass_c%0d", c), 64'(ireq_tvalid_o), 64'd0);
        end
        if (ireq_tvalid_o && ireq_tready_in && ireq_tlast_o) done0 = 1;
        step();
        advance();
      end
      if (!done0) tmo("bub_done", 40);
      en[0] = 1'b0;
      drive_srcs();
      sample();
      chk("bub_gap", 64'(grant_o), 64'd0);
      step();
      drive_srcs();
      sample();
      chk("bub_next", 64'(grant_o), 64'd2);
      step();
      advance();
    end

    // reset in the middle of a requester-1 packet, after pointer has moved to 1
    do_reset();
    plen[0] = 1;
    plen[1] = 4;
    ireq_tready_in = 1'b1;
    en = 2'b01;
    run_until(0, 1, "rst_pre0");
    en = 2'b10;
    run_until(1, 2, "rst_pre1");
    log_rst = 1'b1;
    en = 2'b00;
    drive_srcs();
    step();
    log_rst = 1'b0;
    beat[0] = 0;
    beat[1] = 0;
    drive_srcs();
    sample();
    chk("rstmid_grant", 64'(grant_o), 64'd0);
    chk("rstmid_tvalid", 64'(ireq_tvalid_o), 64'd0);
    chk("rstmid_rdy", 64'(req_tready_o), 64'd0);
    chk("rstmid_cnt", 64'(pkt_cnt_o), 64'd0);
    chk("rstmid_busy", 64'(busy_o), 64'd0);
    step();
    en = 2'b11;
    plen[0] = 4;
    drive_srcs();
    sample();
    chk("rstmid_arb", 64'(grant_o), 64'd0);
    step();
    drive_srcs();
    sample();
    chk("rstmid_ptr", 64'(grant_o), 64'd1);
    step();

`ifdef IREQ_ARB_WDOG_EN
    // stall watchdog: no accepted beats for WD cycles
    do_reset();
    en = 2'b11;
    ireq_tready_in = 1'b0;
    drive_srcs();
    sample();
    step();
    begin
      int  stall;
      bit  fired;
      stall = 0; fired = 0;
      for (int c = 0; c < 40 && !fired; c++) begin
        sample();
        if (wdog_err_o) begin
          fired = 1;
        end else begin
          chk($sformatf("wd_hold_c%0d", c), 64'(grant_o), 64'd1);
          stall++;
          step();
        end
      end
      if (!fired) tmo("wd_fire", 40);
      chk("wd_stall_len", 64'(stall), 64'(WD));
      chk("wd_idle", 64'(grant_o), 64'd0);
      chk("wd_cnt", 64'(pkt_cnt_o), 64'd0);
      step();
      sample();
      chk("wd_pulse_end", 64'(wdog_err_o), 64'd0);
      chk("wd_next", 64'(grant_o), 64'd2);
      chk("wd_cnt2", 64'(pkt_cnt_o), 64'd0);
      step();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
